fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch/decode front end for an 8-bit accumulator-style core
// with a 32x8 combinational-read memory. One instruction per transaction:
// FETCH reads the instruction at pc, DECODE classifies the opcode, OPREAD
// (memory-reference ops only) reads the operand at ir[4:0], and HOLD
// presents the result until downstream accepts it. At the handshake the
// downstream stage may redirect the pc (jump_en/jump_addr).
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   start      : leave IDLE and begin fetching (ignored in other states)
//   mem_data   : combinational read data from memory (8 bits)
//   mem_addr   : memory address (pc, or ir[4:0] during OPREAD)
//   mem_read   : read strobe, high in FETCH and OPREAD only
//   ready      : downstream accepts the presented instruction
//   jump_en    : redirect request, only looked at during the handshake
//   jump_addr  : redirect target
//   valid      : ir/operand/pc_out carry a decoded instruction (HOLD)
//   ir         : instruction register, opcode = ir[7:5], addr = ir[4:0]
//   operand    : mem[ir[4:0]] for memory-reference ops, else 8'h00
//   pc_out     : pc, already advanced past the fetched instruction
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [4:0] RESET_PC = 5'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] mem_data,
  output logic [4:0] mem_addr,
  output logic       mem_read,
  input  logic       ready,
  input  logic       jump_en,
  input  logic [4:0] jump_addr,
  output logic       valid,
  output logic [7:0] ir,
  output logic [7:0] operand,
  output logic [4:0] pc_out
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    OPREAD = 3'd3,
    HOLD   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] operand_q, operand_d;

  // Opcodes 100, 101 and 110 reference memory. 111 (jump class) does not:
  // the redirect is decided downstream and arrives through jump_en.
  logic is_mem_op;
  assign is_mem_op = (ir_q[7:6] == 2'b10) || (ir_q[7:5] == 3'b110);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      operand_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      operand_q <= operand_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        state_d = is_mem_op ? OPREAD : HOLD;
      end
      OPREAD: begin
        state_d = HOLD;
      end
      HOLD: begin
        if (ready) state_d = FETCH;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath next values. Every register holds by default, which is what
  // keeps ir/operand/pc_out frozen while HOLD waits on ready.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    operand_d = operand_q;
    case (state_q)
      FETCH: begin
        ir_d = mem_data;
        // 5-bit add wraps 31 -> 0 on its own.
        pc_d = pc_q + 5'd1;
      end
      DECODE: begin
        if (!is_mem_op) operand_d = 8'h00;
      end
      OPREAD: begin
        operand_d = mem_data;
      end
      HOLD: begin
        // The redirect is only honoured on the accepting cycle.
        if (ready && jump_en) pc_d = jump_addr;
      end
      default: begin
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from state (mem_addr, mem_read, valid); the rest come
  // straight from registers.
  // -------------------------------------------------------------------------
  always_comb begin
    mem_read = 1'b0;
    mem_addr = pc_q;
    valid    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read = 1'b1;
      end
      OPREAD: begin
        mem_read = 1'b1;
        mem_addr = ir_q[4:0];
      end
      HOLD: begin
        valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ir      = ir_q;
  assign operand = operand_q;
  assign pc_out  = pc_q;

endmodule
